// File: rtl/axis_stream_fifo_if.sv
// AXI4-Stream beat bundle (valid/ready handshake plus data, user and last sideband).
interface axis_stream_fifo_if #(
    parameter int DATA_W = 32,
    parameter int USER_W = 1
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tlast;

    modport master (output tvalid, tdata, tuser, tlast, input tready);
    modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/axis_stream_fifo.sv
// DEPTH-entry AXI4-Stream FIFO with registered s_tready, fill level and a
// wrapping count of delivered end-of-packet beats.
module axis_stream_fifo #(
    parameter int DATA_W = 32,
    parameter int USER_W = 1,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    axis_stream_fifo_if.slave            s,
    axis_stream_fifo_if.master           m,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [CNT_W-1:0]             pkt_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [USER_W-1:0] user;
        logic              last;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   count;
    logic [LW-1:0]   count_next;
    logic            ready;
    logic            push;
    logic            pop;
    logic            valid;

    assign valid = (count != '0);
    assign push  = s.tvalid && ready;
    assign pop   = valid && m.tready;

    always_comb begin
        count_next = count + LW'(push) - LW'(pop);
    end

    // Storage is never cleared: reset only discards entries via the pointers.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= '{user: s.tuser, last: s.tlast, data: s.tdata};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ready     <= 1'b0;
            pkt_count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count_next;
            // Registered ready: a pop while full frees a slot only on the next cycle.
            ready  <= (count_next < LW'(DEPTH));
            if (pop && head.last) begin
                pkt_count <= pkt_count + CNT_W'(1);
            end
        end
    end

    assign head     = mem[rd_ptr];
    assign s.tready = ready;
    assign m.tvalid = valid;
    assign m.tdata  = valid ? head.data : '0;
    assign m.tuser  = valid ? head.user : '0;
    assign m.tlast  = valid ? head.last : 1'b0;
    assign level    = count;
endmodule

// File: tb/tb_axis_stream_fifo.sv
// Scoreboard bench for axis_stream_fifo: an occupancy/ready/packet model steps
// alongside the DUT every cycle and popped beats are matched against a queue.
module tb_axis_stream_fifo;
    localparam int DATA_W = 32;
    localparam int USER_W = 2;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 4;
    localparam int LW     = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [USER_W-1:0] user;
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [LW-1:0]    level;
    logic [CNT_W-1:0] pkt_count;

    axis_stream_fifo_if #(.DATA_W(DATA_W), .USER_W(USER_W)) s_bus ();
    axis_stream_fifo_if #(.DATA_W(DATA_W), .USER_W(USER_W)) m_bus ();

    axis_stream_fifo #(
        .DATA_W(DATA_W),
        .USER_W(USER_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .s        (s_bus.slave),
        .m        (m_bus.master),
        .level    (level),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int               vectors = 0;
    int               miscompares = 0;
    beat_t            sb[$];
    int               mdl_level = 0;
    logic [CNT_W-1:0] mdl_pkt = '0;
    logic             mdl_rdy = 1'b0;
    logic             last_push = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Handshakes are decided from the model, then the DUT is checked after the edge.
    task automatic cycle();
        logic  push;
        logic  pop;
        beat_t b;
        push = s_bus.tvalid && mdl_rdy;
        pop  = m_bus.tready && (mdl_level != 0);
        last_push = 1'b0;
        if (reset) begin
            sb.delete();
            mdl_level = 0;
            mdl_pkt   = '0;
            mdl_rdy   = 1'b0;
        end else begin
            if (pop) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'(sb.size()), 64'd1);
                end else begin
                    b = sb.pop_front();
                    check("m_tdata", 64'(m_bus.tdata), 64'(b.data));
                    check("m_tuser", 64'(m_bus.tuser), 64'(b.user));
                    check("m_tlast", 64'(m_bus.tlast), 64'(b.last));
                    if (b.last) mdl_pkt = mdl_pkt + 1'b1;
                end
            end
            if (push) begin
                sb.push_back('{user: s_bus.tuser, last: s_bus.tlast, data: s_bus.tdata});
                last_push = 1'b1;
            end
            mdl_level = mdl_level + int'(push) - int'(pop);
            mdl_rdy   = (mdl_level < DEPTH);
        end
        @(posedge clk);
        #1;
        check("level", 64'(level), 64'(mdl_level));
        check("pkt_count", 64'(pkt_count), 64'(mdl_pkt));
        check("s_tready", 64'(s_bus.tready), 64'(mdl_rdy));
        check("m_tvalid", 64'(m_bus.tvalid), 64'(mdl_level != 0));
        if (mdl_level == 0) begin
            check("idle_tdata", 64'(m_bus.tdata), 64'd0);
            check("idle_tuser", 64'(m_bus.tuser), 64'd0);
            check("idle_tlast", 64'(m_bus.tlast), 64'd0);
        end
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic [USER_W-1:0] u, input logic l);
        s_bus.tvalid = 1'b1;
        s_bus.tdata  = d;
        s_bus.tuser  = u;
        s_bus.tlast  = l;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (last_push) break;
        end
        if (!last_push) check("send_timeout", 64'(last_push), 64'd1);
        s_bus.tvalid = 1'b0;
    endtask

    task automatic drain();
        m_bus.tready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (mdl_level == 0) break;
            cycle();
        end
        check("drain_level", 64'(level), 64'd0);
        check("drain_sb", 64'(sb.size()), 64'd0);
        m_bus.tready = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) cycle();
        reset = 1'b0;
    endtask

    initial begin
        int sent;
        int cyc;
        reset        = 1'b1;
        s_bus.tvalid = 1'b0;
        s_bus.tdata  = '0;
        s_bus.tuser  = '0;
        s_bus.tlast  = 1'b0;
        m_bus.tready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held, then first cycle after release raises s_tready.
        do_reset(3);
        cycle();
        check("t1_s_tready", 64'(s_bus.tready), 64'd1);
        check("t1_level", 64'(level), 64'd0);

        // Single beat latency and pop.
        send(32'hA5A5_0001, 2'd1, 1'b0);
        check("t2_m_tvalid", 64'(m_bus.tvalid), 64'd1);
        check("t2_m_tdata", 64'(m_bus.tdata), 64'hA5A5_0001);
        check("t2_m_tuser", 64'(m_bus.tuser), 64'd1);
        m_bus.tready = 1'b1;
        cycle();
        m_bus.tready = 1'b0;
        check("t2_empty", 64'(m_bus.tvalid), 64'd0);

        // Fill, hold a fifth beat under backpressure, release with one pop.
        for (int i = 0; i < 4; i++) send(32'h10 + 32'(i), 2'(i), 1'b0);
        check("t3_full_level", 64'(level), 64'd4);
        check("t3_full_rdy", 64'(s_bus.tready), 64'd0);
        s_bus.tvalid = 1'b1;
        s_bus.tdata  = 32'h14;
        s_bus.tuser  = 2'd3;
        s_bus.tlast  = 1'b1;
        cycle();
        check("t3_held", 64'(last_push), 64'd0);
        check("t3_held_level", 64'(level), 64'd4);
        m_bus.tready = 1'b1;
        cycle();
        m_bus.tready = 1'b0;
        check("t3_pop_no_push", 64'(last_push), 64'd0);
        check("t3_rdy_back", 64'(s_bus.tready), 64'd1);
        cycle();
        check("t3_fifth_in", 64'(last_push), 64'd1);
        s_bus.tvalid = 1'b0;
        check("t3_head", 64'(m_bus.tdata), 64'h11);
        drain();

        // Random streaming across pointer wrap with AXI-stable held beats.
        sent = 0;
        cyc  = 0;
        while (sent < 1000 && cyc < 8000) begin
            if (!(s_bus.tvalid && !last_push)) begin
                s_bus.tvalid = 1'($urandom_range(0, 1));
                s_bus.tdata  = $urandom;
                s_bus.tuser  = 2'($urandom_range(0, 3));
                s_bus.tlast  = 1'($urandom_range(0, 1));
            end
            m_bus.tready = 1'($urandom_range(0, 1));
            cycle();
            cyc++;
            if (last_push) sent++;
        end
        if (sent < 1000) check("t4_timeout", 64'(sent), 64'd1000);
        s_bus.tvalid = 1'b0;
        drain();

        // Both sides always ready: level stays at one while a beat flows every cycle.
        m_bus.tready = 1'b1;
        s_bus.tvalid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            s_bus.tdata = 32'h100 + 32'(i);
            s_bus.tlast = 1'b0;
            cycle();
            check("t4_rate_push", 64'(last_push), 64'd1);
            check("t4_rate_level", 64'(level), 64'd1);
        end
        s_bus.tvalid = 1'b0;
        drain();

        // Packet counter wrap at CNT_W=4: 17 last beats read back as 1.
        do_reset(1);
        cycle();
        m_bus.tready = 1'b1;
        for (int i = 0; i < 3; i++) send(32'h200 + 32'(i), 2'd0, 1'b0);
        for (int i = 0; i < 17; i++) send(32'h300 + 32'(i), 2'd0, 1'b1);
        drain();
        check("t5_pkt_wrap", 64'(pkt_count), 64'd1);

        // Reset mid-packet with a beat on offer: nothing survives.
        for (int i = 0; i < 3; i++) send(32'h400 + 32'(i), 2'd2, 1'b0);
        check("t6_level3", 64'(level), 64'd3);
        reset        = 1'b1;
        s_bus.tvalid = 1'b1;
        s_bus.tdata  = 32'h77;
        cycle();
        reset        = 1'b0;
        s_bus.tvalid = 1'b0;
        check("t6_level0", 64'(level), 64'd0);
        check("t6_m_tvalid", 64'(m_bus.tvalid), 64'd0);
        check("t6_pkt0", 64'(pkt_count), 64'd0);
        cycle();
        check("t6_rdy", 64'(s_bus.tready), 64'd1);
        send(32'hDEAD_BEEF, 2'd1, 1'b1);
        check("t6_fresh", 64'(m_bus.tdata), 64'hDEAD_BEEF);
        drain();
        check("t6_pkt1", 64'(pkt_count), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
